robo_player: RTL and testbench
==============================

# robo_player

Automated opponent for the tug-of-war game. It watches the 7-bit LED bus that the game drives. When it sees the all-lit "go" pattern, it waits a programmable reaction delay and then presses a button, so one human can play against the board. It sits outside the game core. Its input is the game's LED output, and its button output drives the game's left or right pushbutton input in place of a human.

## Interface
- REACT_W, 8: width of the reaction-delay value and its down-counter.
- PRESS_LEN, 4: press pulse width in clk cycles. Legal range 1..15.
- clk  input  1  system clock, the same clock as the game.
- rst  input  1  asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on the clk rising edge.
- en  input  1  arms the player. While low, the player sits in IDLE and pb stays 0.
- slowen  input  1  one-cycle tick from the game's divide-by-256 enable. The reaction delay is counted in these ticks.
- rand  input  1  LFSR bit used for delay jitter.
- react_dly  input  REACT_W  base reaction delay, in slowen ticks.
- leds_in  input  7  the game's LED output bus.
- pb  output  1  active-high button press toward the game.
- busy  output  1  high in every state except IDLE and ARMED.
- press_cnt  output  8  number of presses issued. Saturates at 255.
- abort_cnt  output  8  number of rounds lost before pressing. Saturates at 255.

## Operation
- Pattern decode, registered:
  - go = (leds_in == 7'h7F)
  - dark = (leds_in == 7'h00)
  - go_q is set only after go has been seen on 2 consecutive clk samples. This is the glitch filter.
- FSM states: IDLE, ARMED, WAIT, PRESS, HOLDOFF.
- IDLE -> ARMED when en=1.
- In any state, en=0 -> IDLE on the next clk. pb drops to 0 in that same cycle.
- ARMED: wait for dark on a sampled cycle, then for go_q.
  - On go_q, load the delay counter with react_dly + rand, where rand is sampled on that cycle.
  - The addition saturates at 2^REACT_W - 1.
  - Go to WAIT.
  - A go_q with no preceding dark since entering ARMED is ignored. This blocks a re-trigger on a stale "go".
- WAIT: the counter decrements on each slowen=1 cycle.
  - When the counter is 0 on a clk edge, go to PRESS. This applies even to a 0 load, so the minimum wait is 1 clk.
  - If go drops (leds_in != 7'h7F) while in WAIT, the opponent has won the round: increment abort_cnt and go to ARMED.
  - If go dropping and the counter reaching 0 occur on the same edge, the abort wins.
- PRESS: pb=1 for exactly PRESS_LEN clk cycles.
  - press_cnt increments once, on entry to PRESS.
  - Then go to HOLDOFF.
  - A loss of go during PRESS does not shorten the pulse.
- HOLDOFF: pb=0. Return to ARMED once leds_in != 7'h7F has been sampled. The ARMED dark requirement then still applies.
- Counters saturate and never wrap.
- react_dly is sampled only at the ARMED -> WAIT transition. Changes during WAIT have no effect.

## Timing
- Reset values:
  - state = IDLE
  - pb = 0, busy = 0
  - press_cnt = 0, abort_cnt = 0
  - delay counter = 0, go filter = 0
- All outputs are registered. There is no combinational path from an input to an output.
- go_q latency: if go is first present on clk edge N, go_q is 1 after edge N+1.
- With go_q=1 in ARMED, WAIT is entered on the next edge.
- From WAIT entry with a load of D, pb rises on the first clk edge after the (D)th slowen tick.
  - D=0: pb rises 1 edge after WAIT entry.
- pb stays high for exactly PRESS_LEN consecutive clk cycles.
- press_cnt updates on the same edge that pb rises.
- busy is 1 in WAIT, PRESS and HOLDOFF.
- Reset asserted mid-press: pb goes 0 asynchronously and the state returns to IDLE.

## Test plan
- Normal round:
  - Stimulus: rst released, en=1, react_dly=3, rand=0. leds 00 for 5 clk, then 7F held. slowen every 4th clk.
  - Required: pb goes high after the 3rd slowen, stays high 4 clk, press_cnt=1, FSM in HOLDOFF until leds change.
- Opponent wins first:
  - Stimulus: react_dly=10. leds 00 -> 7F, then after 5 slowen ticks leds -> 7'h08.
  - Required: pb never rises, abort_cnt=1, FSM in ARMED.
- Stale go / glitch:
  - Stimulus 1: en rises while leds=7F already.
  - Required 1: no press until leds go 00 and then 7F again.
  - Stimulus 2: a single-cycle 7F blip.
  - Required 2: no WAIT entry.
- Boundaries:
  - Stimulus 1: react_dly=0.
  - Required 1: pb rises 1 clk after WAIT entry.
  - Stimulus 2: react_dly=255 with rand=1.
  - Required 2: load saturates to 255.
  - Stimulus 3: issue 256 presses.
  - Required 3: press_cnt stays at 255.
- Simultaneous abort and expiry:
  - Stimulus: leds leave 7F on the same edge the counter reaches 0.
  - Required: no pb, abort_cnt increments.
- Reset and disable mid-operation:
  - Stimulus 1: rst=0 in the 2nd cycle of PRESS.
  - Required 1: pb=0 immediately, all counters 0.
  - Stimulus 2: en=0 during WAIT.
  - Required 2: IDLE next clk, busy=0.

Source files
------------

// File: rtl/robo_player_if.sv
// Signal bundle between the tug-of-war game and the robo_player opponent.
// The master side is whatever drives the player: game LEDs, tick, jitter and controls.
// The slave side is the player itself.
interface robo_player_if #(
  parameter int REACT_W = 8
);
  logic               i_en;
  logic               i_slowen;
  logic               i_rand;
  logic [REACT_W-1:0] i_react_dly;
  logic [6:0]         i_leds_in;
  logic               o_pb;
  logic               o_busy;
  logic [7:0]         o_press_cnt;
  logic [7:0]         o_abort_cnt;

  modport master (
    output i_en, i_slowen, i_rand, i_react_dly, i_leds_in,
    input  o_pb, o_busy, o_press_cnt, o_abort_cnt
  );

  modport slave (
    input  i_en, i_slowen, i_rand, i_react_dly, i_leds_in,
    output o_pb, o_busy, o_press_cnt, o_abort_cnt
  );
endinterface

// File: rtl/robo_player.sv
// Automated tug-of-war opponent: watches the game's LED bus for the all-lit
// "go" pattern, waits a jittered reaction delay counted in slow ticks, then
// issues a fixed-width button press. All outputs are registered.
module robo_player #(
  parameter int REACT_W   = 8,
  parameter int PRESS_LEN = 4
) (
  input logic          clk,
  input logic          rst,
  robo_player_if.slave bus
);

  localparam logic [REACT_W-1:0] CNT_MAX    = '1;
  localparam logic [3:0]         PRESS_LAST = 4'(PRESS_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_PRESS,
    S_HOLDOFF
  } state_t;

  state_t             r_state;
  logic               r_go_d;
  logic               r_go_q;
  logic               r_dark;
  logic               r_dark_seen;
  logic [REACT_W-1:0] r_cnt;
  logic [3:0]         r_plen;
  logic               r_pb;
  logic               r_busy;
  logic [7:0]         r_press_cnt;
  logic [7:0]         r_abort_cnt;

  logic               w_go;
  logic               w_dark;
  logic [REACT_W:0]   w_sum;
  logic [REACT_W-1:0] w_load;

  assign w_go   = (bus.i_leds_in == 7'h7F);
  assign w_dark = (bus.i_leds_in == 7'h00);

  // Reaction delay plus one jitter tick, clamped to the counter's range.
  assign w_sum  = {1'b0, bus.i_react_dly} + (REACT_W + 1)'(bus.i_rand);
  assign w_load = w_sum[REACT_W] ? CNT_MAX : w_sum[REACT_W-1:0];

  assign bus.o_pb        = r_pb;
  assign bus.o_busy      = r_busy;
  assign bus.o_press_cnt = r_press_cnt;
  assign bus.o_abort_cnt = r_abort_cnt;

  // Registered pattern decode; go_q needs two consecutive go samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_go_d <= 1'b0;
      r_go_q <= 1'b0;
      r_dark <= 1'b0;
    end else begin
      r_go_d <= w_go;
      r_go_q <= w_go & r_go_d;
      r_dark <= w_dark;
    end
  end

  // Player FSM with registered pb/busy and saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dark_seen <= 1'b0;
      r_cnt       <= '0;
      r_plen      <= '0;
      r_pb        <= 1'b0;
      r_busy      <= 1'b0;
      r_press_cnt <= '0;
      r_abort_cnt <= '0;
    end else if (!bus.i_en) begin
      r_state     <= S_IDLE;
      r_dark_seen <= 1'b0;
      r_pb        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_ARMED;
          r_dark_seen <= 1'b0;
        end
        S_ARMED: begin
          if (r_dark_seen && r_go_q) begin
            r_cnt   <= w_load;
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end else if (r_dark) begin
            r_dark_seen <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!w_go) begin
            r_abort_cnt <= (r_abort_cnt == 8'hFF) ? r_abort_cnt : r_abort_cnt + 8'd1;
            r_state     <= S_ARMED;
            r_dark_seen <= 1'b0;
            r_busy      <= 1'b0;
          end else if (r_cnt == '0) begin
            r_press_cnt <= (r_press_cnt == 8'hFF) ? r_press_cnt : r_press_cnt + 8'd1;
            r_state     <= S_PRESS;
            r_plen      <= PRESS_LAST;
            r_pb        <= 1'b1;
          end else if (bus.i_slowen) begin
            r_cnt <= r_cnt - REACT_W'(1);
          end
        end
        S_PRESS: begin
          if (r_plen == '0) begin
            r_state <= S_HOLDOFF;
            r_pb    <= 1'b0;
          end else begin
            r_plen <= r_plen - 4'd1;
          end
        end
        S_HOLDOFF: begin
          if (!w_go) begin
            r_state     <= S_ARMED;
            r_dark_seen <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_pb    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robo_player.sv
// Bench for robo_player: scenario table, hand-written corner sequences and a
// randomized run, all compared cycle by cycle against an event-level model.
module tb_robo_player;

  localparam int REACT_W   = 8;
  localparam int PRESS_LEN = 4;

  logic clk = 1'b0;
  logic rst;

  robo_player_if #(.REACT_W(REACT_W)) bus ();

  robo_player #(.REACT_W(REACT_W), .PRESS_LEN(PRESS_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_on, m_dark_seen, m_counting, m_pressing, m_holding;
  int m_ticks, m_age, m_presses, m_aborts, m_h1, m_h2;

  task automatic model_reset();
    m_on = 0; m_dark_seen = 0; m_counting = 0; m_pressing = 0; m_holding = 0;
    m_ticks = 0; m_age = 0; m_presses = 0; m_aborts = 0;
    m_h1 = -1; m_h2 = -1;
  endtask

  task automatic model_step();
    bit go_now, goq, darkq;
    int lv;
    lv     = int'(bus.i_leds_in);
    go_now = (lv == 127);
    goq    = (m_h1 == 127) && (m_h2 == 127);
    darkq  = (m_h1 == 0);
    if (!bus.i_en) begin
      m_on = 0; m_counting = 0; m_pressing = 0; m_holding = 0;
    end else if (!m_on) begin
      m_on = 1; m_dark_seen = 0;
    end else if (m_counting) begin
      if (!go_now) begin
        m_counting = 0; m_dark_seen = 0;
        if (m_aborts < 255) m_aborts++;
      end else if (m_ticks == 0) begin
        m_counting = 0; m_pressing = 1; m_age = 0;
        if (m_presses < 255) m_presses++;
      end else if (bus.i_slowen) begin
        m_ticks--;
      end
    end else if (m_pressing) begin
      m_age++;
      if (m_age == PRESS_LEN) begin
        m_pressing = 0; m_holding = 1;
      end
    end else if (m_holding) begin
      if (!go_now) begin
        m_holding = 0; m_dark_seen = 0;
      end
    end else begin
      if (m_dark_seen && goq) begin
        m_counting = 1;
        m_ticks = int'(bus.i_react_dly) + int'(bus.i_rand);
        if (m_ticks > 255) m_ticks = 255;
      end else if (darkq) begin
        m_dark_seen = 1;
      end
    end
    m_h2 = m_h1;
    m_h1 = lv;
  endtask

  task automatic check_model();
    chk("mdl_pb",    int'(bus.o_pb),        int'(m_pressing));
    chk("mdl_busy",  int'(bus.o_busy),      int'(m_counting | m_pressing | m_holding));
    chk("mdl_press", int'(bus.o_press_cnt), m_presses);
    chk("mdl_abort", int'(bus.o_abort_cnt), m_aborts);
  endtask

  // Inputs are set at the falling edge; one call covers one clk edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  // Reset, enable and show dark long enough to be armed with dark seen.
  task automatic arm();
    do_reset();
    bus.i_en = 1'b1; bus.i_slowen = 1'b0; bus.i_rand = 1'b0;
    bus.i_react_dly = '0; bus.i_leds_in = 7'h00;
    repeat (5) tick();
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int dly;
    int rnd;
    int period;
    int abort_k;
    int exp_lat;
    int exp_press;
    int exp_abort;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    int rise, hi, kmax;
    rise = -1; hi = 0;
    arm();
    kmax = ((v.exp_lat >= 0) ? v.exp_lat : v.abort_k) + PRESS_LEN + 3;
    for (int k = 0; k <= kmax; k++) begin
      bus.i_leds_in   = (v.abort_k >= 0 && k >= v.abort_k) ? 7'h08 : 7'h7F;
      bus.i_slowen    = ((k % v.period) == v.period - 1);
      bus.i_react_dly = (k < 3) ? 8'(v.dly) : ~8'(v.dly);
      bus.i_rand      = (k < 3) ? 1'(v.rnd) : ~1'(v.rnd);
      tick();
      if (bus.o_pb) begin
        hi++;
        if (rise < 0) rise = k;
      end
    end
    chk($sformatf("vec%0d_rise", idx),    rise, v.exp_lat);
    chk($sformatf("vec%0d_pbwidth", idx), hi, (v.exp_lat >= 0) ? PRESS_LEN : 0);
    chk($sformatf("vec%0d_press", idx),   int'(bus.o_press_cnt), v.exp_press);
    chk($sformatf("vec%0d_abort", idx),   int'(bus.o_abort_cnt), v.exp_abort);
    chk($sformatf("vec%0d_busy", idx),    int'(bus.o_busy), (v.exp_lat >= 0) ? 1 : 0);
  endtask

  task automatic run_random();
    int sel, len;
    logic [6:0] pat;
    arm();
    for (int s = 0; s < 250; s++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 25);
      pat = (sel < 4) ? 7'h00 : (sel < 8) ? 7'h7F : 7'($urandom);
      for (int j = 0; j < len; j++) begin
        bus.i_leds_in   = pat;
        bus.i_en        = ($urandom_range(0, 199) != 0);
        bus.i_slowen    = ($urandom_range(0, 2) == 0);
        bus.i_rand      = 1'($urandom);
        bus.i_react_dly = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(250, 255))
                                                       : 8'($urandom_range(0, 6));
        tick();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_pb, cnt_busy, rise;

    //           dly  rnd per abort_k lat press abort
    vecs[0] = '{  3,  0,  4,  -1,  12,  1,  0};  // normal round
    vecs[1] = '{  0,  0,  4,  -1,   3,  1,  0};  // zero delay
    vecs[2] = '{  1,  0,  4,  -1,   4,  1,  0};
    vecs[3] = '{  2,  0,  1,  -1,   5,  1,  0};  // tick every clk
    vecs[4] = '{  3,  1,  2,  -1,  10,  1,  0};  // jitter adds one tick
    vecs[5] = '{255,  1,  1,  -1, 258,  1,  0};  // load saturates at 255
    vecs[6] = '{ 10,  0,  4,  20,  -1,  0,  1};  // opponent wins first
    vecs[7] = '{  2,  0,  4,   8,  -1,  0,  1};  // abort on expiry edge

    rst = 1'b0;
    bus.i_en = 1'b0; bus.i_slowen = 1'b0; bus.i_rand = 1'b0;
    bus.i_react_dly = '0; bus.i_leds_in = 7'h00;
    model_reset();
    @(negedge clk);
    chk("rst_pb",    int'(bus.o_pb), 0);
    chk("rst_busy",  int'(bus.o_busy), 0);
    chk("rst_press", int'(bus.o_press_cnt), 0);
    chk("rst_abort", int'(bus.o_abort_cnt), 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Stale go: enabled while already lit, must wait for dark then go again.
    do_reset();
    bus.i_en = 1'b1; bus.i_slowen = 1'b1; bus.i_rand = 1'b0;
    bus.i_react_dly = '0; bus.i_leds_in = 7'h7F;
    cnt_pb = 0; cnt_busy = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt_pb += int'(bus.o_pb);
      cnt_busy += int'(bus.o_busy);
    end
    chk("stale_no_pb",   cnt_pb, 0);
    chk("stale_no_busy", cnt_busy, 0);
    bus.i_leds_in = 7'h00;
    repeat (2) tick();
    rise = -1;
    for (int k = 0; k < 10; k++) begin
      bus.i_leds_in = 7'h7F;
      tick();
      if (bus.o_pb && rise < 0) rise = k;
    end
    chk("stale_then_go_rise", rise, 3);

    // Single-cycle go blip never reaches WAIT.
    arm();
    bus.i_leds_in = 7'h7F;
    tick();
    cnt_busy = int'(bus.o_busy);
    bus.i_leds_in = 7'h00;
    for (int k = 0; k < 15; k++) begin
      tick();
      cnt_busy += int'(bus.o_busy);
    end
    chk("blip_no_wait", cnt_busy, 0);

    // Reset asserted in the second cycle of a press.
    arm();
    bus.i_leds_in = 7'h7F;
    repeat (5) tick();
    chk("midpress_pb_high", int'(bus.o_pb), 1);
    rst = 1'b0;
    #1;
    chk("midpress_rst_pb",    int'(bus.o_pb), 0);
    chk("midpress_rst_busy",  int'(bus.o_busy), 0);
    chk("midpress_rst_press", int'(bus.o_press_cnt), 0);
    chk("midpress_rst_abort", int'(bus.o_abort_cnt), 0);
    model_reset();
    rst = 1'b1;

    // en dropped during WAIT returns to IDLE on the next edge.
    arm();
    bus.i_react_dly = 8'd50;
    for (int k = 0; k < 5; k++) begin
      bus.i_leds_in = 7'h7F;
      bus.i_slowen  = ((k % 4) == 3);
      tick();
    end
    chk("wait_busy", int'(bus.o_busy), 1);
    bus.i_en = 1'b0;
    tick();
    chk("disable_busy", int'(bus.o_busy), 0);
    chk("disable_pb",   int'(bus.o_pb), 0);

    // 260 quick rounds: press count must stop at 255.
    arm();
    bus.i_react_dly = '0;
    for (int r = 0; r < 260; r++) begin
      bus.i_leds_in = 7'h7F;
      repeat (8) tick();
      bus.i_leds_in = 7'h00;
      repeat (2) tick();
      if (r == 254) chk("press_cnt_255", int'(bus.o_press_cnt), 255);
    end
    chk("press_cnt_sat", int'(bus.o_press_cnt), 255);

    run_random();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
